mem_multiport_ctrl: RTL and testbench

Byte-serial RAM controller that arbitrates NUM_PORTS requesters onto the single 8-bit RAM port and assembles or splits 1/2/4-byte accesses. It is a parametrised successor of the two-port fetch/data controller and sits in riscv_top between the RAM and the requesters (port 0 = mem stage, port 1 = i_cache, further ports e.g. d_cache refill). It adds selectable fixed-priority or round-robin arbitration, a per-port done pulse, and sign/zero extension of sub-word loads.

---
 rtl/mem_multiport_ctrl_pkg.sv | 45 ++++
 rtl/mem_multiport_ctrl_if.sv | 27 ++
 rtl/mem_multiport_ctrl_arbiter.sv | 72 +++++++
 rtl/mem_multiport_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mem_multiport_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_multiport_ctrl_pkg.sv
// Shared types, encodings and helpers for the multi-port byte-serial RAM controller.
package mem_multiport_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  // Access size encodings (size[1:0]); 2'b11 behaves as a word.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // size[ZEXT_BIT] = 1 selects zero-extension of sub-word loads.
  localparam int ZEXT_BIT = 2;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Number of RAM bytes moved for a given size code.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Sign- or zero-extend an assembled little-endian load result.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] sz);
    logic [31:0] r;
    case (sz[1:0])
      SZ_B:    r = sz[ZEXT_BIT] ? {24'h00_0000, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      SZ_H:    r = sz[ZEXT_BIT] ? {16'h0000, w[15:0]}    : {{16{w[15]}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_multiport_ctrl_if.sv
// Requester-side bus of the multi-port RAM controller: flattened per-port
// request fields plus the shared completion/result signals.
interface mem_multiport_ctrl_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32
);
  import mem_multiport_ctrl_pkg::*;

  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        rw;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*32-1:0]     wdata;
  logic [NUM_PORTS*3-1:0]      size;
  logic [NUM_PORTS-1:0]        busy;
  logic [NUM_PORTS-1:0]        done;
  logic [31:0]                 rdata;

  modport master (
    output req, rw, addr, wdata, size,
    input  busy, done, rdata
  );

  modport slave (
    input  req, rw, addr, wdata, size,
    output busy, done, rdata
  );
endinterface

// File: rtl/mem_multiport_ctrl_arbiter.sv
// Requester arbiter: combinational grant from the candidate set, either
// fixed priority (lowest index) or round-robin from a registered pointer.
module mem_port_arbiter
  import mem_multiport_ctrl_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE  = 0,
  parameter int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] cand_i,
  input  logic                 accept_i,
  output logic                 gnt_valid_o,
  output logic [PW-1:0]        gnt_idx_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] gnt_idx_d;
  logic          gnt_valid_d;
  int            idx_v;

  // Scan candidates starting at the pointer (round-robin) or at port 0.
  always_comb begin
    gnt_valid_d = 1'b0;
    gnt_idx_d   = '0;
    idx_v       = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ARB_MODE == 1) begin
        idx_v = int'(ptr_q) + i;
      end else begin
        idx_v = i;
      end
      if (idx_v >= NUM_PORTS) begin
        idx_v = idx_v - NUM_PORTS;
      end else begin
        idx_v = idx_v;
      end
      if (!gnt_valid_d && cand_i[PW'(idx_v)]) begin
        gnt_valid_d = 1'b1;
        gnt_idx_d   = PW'(idx_v);
      end else begin
        gnt_valid_d = gnt_valid_d;
      end
    end
  end

  // Pointer moves to the port after the winner, wrapping at NUM_PORTS.
  always_comb begin
    if (gnt_idx_d == PW'(NUM_PORTS - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt_idx_d + PW'(1);
    end
  end

  // Round-robin pointer register; only advances when a grant is taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if ((ARB_MODE == 1) && accept_i && gnt_valid_d) begin
      ptr_q <= ptr_d;
    end else begin
      ptr_q <= ptr_q;
    end
  end

  assign gnt_valid_o = gnt_valid_d;
  assign gnt_idx_o   = gnt_idx_d;

endmodule

// File: rtl/mem_multiport_ctrl.sv
// Byte-serial RAM controller: arbitrates NUM_PORTS requesters onto one
// 8-bit RAM port and splits/assembles 1, 2 and 4 byte accesses.
module mem_multiport_ctrl
  import mem_multiport_ctrl_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int ARB_MODE  = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_multiport_ctrl_if.slave bus_if,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [7:0]          ram_wdata_o,
  output logic                ram_rw_o,
  input  logic [7:0]          ram_rdata_i
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_e               state_q;
  logic [PW-1:0]        port_q;
  logic [2:0]           cnt_q;
  logic [2:0]           nbytes_q;
  logic [2:0]           size_q;
  logic [31:0]          rbuf_q;
  logic [31:0]          wbuf_q;
  logic [NUM_PORTS-1:0] busy_q;
  logic [NUM_PORTS-1:0] done_q;
  logic [31:0]          rdata_q;
  logic [ADDR_W-1:0]    ram_addr_q;
  logic [7:0]           ram_wdata_q;
  logic                 ram_rw_q;

  logic [NUM_PORTS-1:0] cand_s;
  logic                 gnt_valid_s;
  logic [PW-1:0]        gnt_idx_s;
  logic [NUM_PORTS-1:0] gnt_onehot_s;
  logic [NUM_PORTS-1:0] port_onehot_s;
  logic [ADDR_W-1:0]    sel_addr_s;
  logic [31:0]          sel_wdata_s;
  logic [2:0]           sel_size_s;
  logic                 sel_rw_s;
  logic [31:0]          rword_d;
  logic [31:0]          rdata_d;

  // A port whose done is high this cycle is not a candidate again yet.
  assign cand_s = bus_if.req & ~done_q;

  mem_port_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .ARB_MODE  (ARB_MODE),
    .PW        (PW)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cand_i      (cand_s),
    .accept_i    (state_q == ST_IDLE),
    .gnt_valid_o (gnt_valid_s),
    .gnt_idx_o   (gnt_idx_s)
  );

  assign gnt_onehot_s  = NUM_PORTS'(1) << gnt_idx_s;
  assign port_onehot_s = NUM_PORTS'(1) << port_q;

  // Mux the winning port's request fields out of the flattened bus.
  always_comb begin
    sel_addr_s  = '0;
    sel_wdata_s = ZERO_WORD;
    sel_size_s  = 3'b000;
    sel_rw_s    = RW_READ;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_idx_s == PW'(p)) begin
        sel_addr_s  = bus_if.addr[p*ADDR_W +: ADDR_W];
        sel_wdata_s = bus_if.wdata[p*32 +: 32];
        sel_size_s  = bus_if.size[p*3 +: 3];
        sel_rw_s    = bus_if.rw[p];
      end else begin
        sel_rw_s = sel_rw_s;
      end
    end
  end

  // Merge the byte on ram_rdata into the load buffer; cnt_q-1 is its lane.
  always_comb begin
    rword_d = rbuf_q;
    case (cnt_q)
      3'd1:    rword_d[7:0]   = ram_rdata_i;
      3'd2:    rword_d[15:8]  = ram_rdata_i;
      3'd3:    rword_d[23:16] = ram_rdata_i;
      3'd4:    rword_d[31:24] = ram_rdata_i;
      default: rword_d = rbuf_q;
    endcase
    rdata_d = load_extend(rword_d, size_q);
  end

  // Transfer FSM: grant in IDLE, then stream bytes in RD or WR.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      port_q      <= '0;
      cnt_q       <= 3'd0;
      nbytes_q    <= 3'd0;
      size_q      <= 3'b000;
      rbuf_q      <= ZERO_WORD;
      wbuf_q      <= ZERO_WORD;
      busy_q      <= '0;
      done_q      <= '0;
      rdata_q     <= ZERO_WORD;
      ram_addr_q  <= '0;
      ram_wdata_q <= 8'h00;
      ram_rw_q    <= RW_READ;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid_s) begin
            port_q     <= gnt_idx_s;
            busy_q     <= gnt_onehot_s;
            size_q     <= sel_size_s;
            nbytes_q   <= size_bytes(sel_size_s[1:0]);
            cnt_q      <= 3'd0;
            rbuf_q     <= ZERO_WORD;
            ram_addr_q <= sel_addr_s;
            if (sel_rw_s == RW_WRITE) begin
              state_q     <= ST_WR;
              ram_rw_q    <= RW_WRITE;
              ram_wdata_q <= sel_wdata_s[7:0];
              wbuf_q      <= {8'h00, sel_wdata_s[31:8]};
            end else begin
              state_q  <= ST_RD;
              ram_rw_q <= RW_READ;
            end
          end
        end
        ST_RD: begin
          // Byte cnt_q-1 arrives this cycle; address runs one byte ahead.
          if (cnt_q != 3'd0) begin
            rbuf_q <= rword_d;
          end
          if (cnt_q == nbytes_q) begin
            done_q  <= port_onehot_s;
            busy_q  <= '0;
            rdata_q <= rdata_d;
            state_q <= ST_IDLE;
          end else begin
            if ((cnt_q + 3'd1) < nbytes_q) begin
              ram_addr_q <= ram_addr_q + ADDR_W'(1);
            end
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_WR: begin
          if ((cnt_q + 3'd1) < nbytes_q) begin
            ram_addr_q  <= ram_addr_q + ADDR_W'(1);
            ram_wdata_q <= wbuf_q[7:0];
            wbuf_q      <= {8'h00, wbuf_q[31:8]};
            cnt_q       <= cnt_q + 3'd1;
          end else begin
            ram_rw_q <= RW_READ;
            done_q   <= port_onehot_s;
            busy_q   <= '0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= '0;
          ram_rw_q <= RW_READ;
        end
      endcase
    end
  end

  assign bus_if.busy  = busy_q;
  assign bus_if.done  = done_q;
  assign bus_if.rdata = rdata_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_wdata_o  = ram_wdata_q;
  assign ram_rw_o     = ram_rw_q;

endmodule

// File: tb/tb_mem_multiport_ctrl.sv
// Directed bench: a 2-port fixed-priority controller with a byte RAM model,
// and a 3-port round-robin controller for grant-order checks.
module tb_mem_multiport_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- DUT 0: 2 ports, fixed priority ----------------
  mem_multiport_ctrl_if #(.NUM_PORTS(2), .ADDR_W(32)) bus0 ();
  logic [1:0]  req0   = 2'b00;
  logic [1:0]  rw0    = 2'b00;
  logic [63:0] addr0  = 64'h0;
  logic [63:0] wdata0 = 64'h0;
  logic [5:0]  size0  = 6'h0;
  assign bus0.req   = req0;
  assign bus0.rw    = rw0;
  assign bus0.addr  = addr0;
  assign bus0.wdata = wdata0;
  assign bus0.size  = size0;

  logic [31:0] ram_addr0;
  logic [7:0]  ram_wdata0;
  logic        ram_rw0;
  logic [7:0]  ram_rdata0 = 8'h00;

  mem_multiport_ctrl #(.NUM_PORTS(2), .ADDR_W(32), .ARB_MODE(0)) u_dut0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus_if      (bus0),
    .ram_addr_o  (ram_addr0),
    .ram_wdata_o (ram_wdata0),
    .ram_rw_o    (ram_rw0),
    .ram_rdata_i (ram_rdata0)
  );

  // Byte RAM model (512 bytes, low address bits) with a bench preload port.
  logic [7:0]  mem0 [0:511];
  logic        pl_en   = 1'b0;
  logic [8:0]  pl_addr = 9'h0;
  logic [7:0]  pl_data = 8'h0;
  always @(posedge clk) begin
    if (pl_en) mem0[pl_addr] <= pl_data;
    else if (ram_rw0) mem0[ram_addr0[8:0]] <= ram_wdata0;
    ram_rdata0 <= mem0[ram_addr0[8:0]];
  end

  // ---------------- DUT 1: 3 ports, round-robin ----------------
  mem_multiport_ctrl_if #(.NUM_PORTS(3), .ADDR_W(32)) bus1 ();
  logic [2:0]  req1   = 3'b000;
  logic [2:0]  rw1    = 3'b000;
  logic [95:0] addr1  = 96'h0;
  logic [95:0] wdata1 = 96'h0;
  logic [8:0]  size1  = 9'h0;
  assign bus1.req   = req1;
  assign bus1.rw    = rw1;
  assign bus1.addr  = addr1;
  assign bus1.wdata = wdata1;
  assign bus1.size  = size1;

  logic [31:0] ram_addr1;
  logic [7:0]  ram_wdata1;
  logic        ram_rw1;
  logic [7:0]  ram_rdata1 = 8'h00;

  mem_multiport_ctrl #(.NUM_PORTS(3), .ADDR_W(32), .ARB_MODE(1)) u_dut1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus_if      (bus1),
    .ram_addr_o  (ram_addr1),
    .ram_wdata_o (ram_wdata1),
    .ram_rw_o    (ram_rw1),
    .ram_rdata_i (ram_rdata1)
  );

  logic [31:0] exp_rdata = 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [8:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic set_port(input logic pid, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] sz);
    rw0[pid] = w;
    addr0[{pid, 5'b0} +: 32]  = a;
    wdata0[{pid, 5'b0} +: 32] = wd;
    if (pid) size0[5:3] = sz; else size0[2:0] = sz;
    req0[pid] = 1'b1;
  endtask

  // Read of n bytes: address A+k in T+1+k, done and rdata at T+n+2.
  task automatic do_read(input string tag, input logic pid, input logic [31:0] a,
                         input logic [2:0] sz, input int n, input logic [31:0] exp);
    logic [31:0] ea;
    set_port(pid, 1'b0, a, 32'h0, sz);
    for (int k = 0; k < n; k++) begin
      tick();
      ea = a + 32'(k);
      chk({tag, "_addr"}, ram_addr0, ea);
      chk({tag, "_busy"}, 32'(bus0.busy), 32'(2'b01 << pid));
    end
    tick();
    chk({tag, "_nodone"}, 32'(bus0.done), 32'h0);
    tick();
    chk({tag, "_done"}, 32'(bus0.done), 32'(2'b01 << pid));
    chk({tag, "_rdata"}, bus0.rdata, exp);
    req0[pid] = 1'b0;
    exp_rdata = exp;
    tick();
    chk({tag, "_idle"}, 32'({bus0.busy, bus0.done}), 32'h0);
  endtask

  // Write of n bytes: rw=1, A+k, byte k in T+1+k; done and rw=0 at T+n+1.
  task automatic do_write(input string tag, input logic pid, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] wd, input int n);
    logic [31:0] ea;
    logic [31:0] eb;
    set_port(pid, 1'b1, a, wd, sz);
    for (int k = 0; k < n; k++) begin
      tick();
      ea = a + 32'(k);
      eb = (wd >> (8 * k)) & 32'h0000_00FF;
      chk({tag, "_rw"}, 32'(ram_rw0), 32'h1);
      chk({tag, "_addr"}, ram_addr0, ea);
      chk({tag, "_wdata"}, 32'(ram_wdata0), eb);
    end
    tick();
    chk({tag, "_done"}, 32'(bus0.done), 32'(2'b01 << pid));
    chk({tag, "_rw_off"}, 32'(ram_rw0), 32'h0);
    chk({tag, "_rdata_held"}, bus0.rdata, exp_rdata);
    req0[pid] = 1'b0;
    tick();
    chk({tag, "_idle"}, 32'({bus0.busy, bus0.done}), 32'h0);
  endtask

  logic [2:0] rec [6];
  int         nrec;
  logic [2:0] prev_busy;

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_busy", 32'(bus0.busy), 32'h0);
    chk("rst_done", 32'(bus0.done), 32'h0);
    chk("rst_rdata", bus0.rdata, 32'h0);
    chk("rst_ram_rw", 32'(ram_rw0), 32'h0);
    chk("rst_ram_addr", ram_addr0, 32'h0);
    chk("rst_ram_wdata", 32'(ram_wdata0), 32'h0);
    rst = 1'b0;

    preload(9'h100, 8'h78);
    preload(9'h101, 8'h56);
    preload(9'h102, 8'h34);
    preload(9'h103, 8'h12);
    preload(9'h020, 8'h80);
    preload(9'h030, 8'h01);
    preload(9'h031, 8'h80);
    tick();

    do_read("lw_p1", 1'b1, 32'h0000_0100, 3'b010, 4, 32'h1234_5678);
    do_read("lw_sz11", 1'b0, 32'h0000_0100, 3'b011, 4, 32'h1234_5678);
    do_read("lb_sext", 1'b0, 32'h0000_0020, 3'b000, 1, 32'hFFFF_FF80);
    do_read("lb_zext", 1'b0, 32'h0000_0020, 3'b100, 1, 32'h0000_0080);
    do_read("lh_sext", 1'b0, 32'h0000_0030, 3'b001, 2, 32'hFFFF_8001);
    do_write("sw", 1'b0, 32'h0000_0040, 3'b010, 32'hDEAD_BEEF, 4);
    do_write("sh_wrap", 1'b1, 32'hFFFF_FFFF, 3'b001, 32'h0000_A55A, 2);
    do_read("lh_wrap", 1'b0, 32'hFFFF_FFFF, 3'b001, 2, 32'hFFFF_A55A);

    // req dropped after grant: access still completes
    set_port(1'b0, 1'b0, 32'h0000_0020, 32'h0, 3'b000);
    tick();
    req0[0] = 1'b0;
    tick();
    chk("drop_nodone", 32'(bus0.done), 32'h0);
    tick();
    chk("drop_done", 32'(bus0.done), 32'h1);
    chk("drop_rdata", bus0.rdata, 32'hFFFF_FF80);
    tick();
    chk("drop_idle", 32'({bus0.busy, bus0.done}), 32'h0);

    // Simultaneous requests, fixed priority: port 0 first, then port 1
    set_port(1'b0, 1'b1, 32'h0000_0050, 32'h0000_0011, 3'b000);
    set_port(1'b1, 1'b0, 32'h0000_0020, 32'h0, 3'b100);
    tick();
    chk("prio_busy0", 32'(bus0.busy), 32'h1);
    chk("prio_wr_addr", ram_addr0, 32'h0000_0050);
    tick();
    chk("prio_done0", 32'(bus0.done), 32'h1);
    req0[0] = 1'b0;
    tick();
    chk("prio_busy1", 32'(bus0.busy), 32'h2);
    chk("prio_rd_addr", ram_addr0, 32'h0000_0020);
    tick();
    chk("prio_nodone1", 32'(bus0.done), 32'h0);
    tick();
    chk("prio_done1", 32'(bus0.done), 32'h2);
    chk("prio_rdata1", bus0.rdata, 32'h0000_0080);
    req0[1] = 1'b0;
    tick();
    chk("prio_idle", 32'({bus0.busy, bus0.done}), 32'h0);

    // Reset in the middle of a word read: no done, controller idles
    set_port(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b010);
    tick();
    chk("rstrd_busy", 32'(bus0.busy), 32'h2);
    tick();
    rst = 1'b1;
    req0[1] = 1'b0;
    tick();
    rst = 1'b0;
    chk("rstrd_busy0", 32'(bus0.busy), 32'h0);
    chk("rstrd_rw0", 32'(ram_rw0), 32'h0);
    chk("rstrd_rdata0", bus0.rdata, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstrd_nodone", 32'(bus0.done), 32'h0);
    end

    // Reset in the middle of a word write: ram_rw drops next cycle
    set_port(1'b0, 1'b1, 32'h0000_0040, 32'h0102_0304, 3'b010);
    tick();
    chk("rstwr_rw1", 32'(ram_rw0), 32'h1);
    tick();
    rst = 1'b1;
    req0[0] = 1'b0;
    tick();
    rst = 1'b0;
    chk("rstwr_rw0", 32'(ram_rw0), 32'h0);
    chk("rstwr_busy0", 32'(bus0.busy), 32'h0);
    tick();
    chk("rstwr_nodone", 32'(bus0.done), 32'h0);

    // Round-robin with all three ports requesting byte reads continuously
    size1 = 9'h0;
    rw1   = 3'b000;
    addr1 = 96'h0;
    req1  = 3'b111;
    nrec  = 0;
    prev_busy = 3'b000;
    for (int c = 0; c < 60; c++) begin
      tick();
      if ((bus1.busy != 3'b000) && (prev_busy == 3'b000) && (nrec < 6)) begin
        rec[nrec] = bus1.busy;
        nrec++;
      end
      prev_busy = bus1.busy;
    end
    req1 = 3'b000;
    chk("rr_count", 32'(nrec), 32'd6);
    chk("rr_g0", 32'(rec[0]), 32'h1);
    chk("rr_g1", 32'(rec[1]), 32'h2);
    chk("rr_g2", 32'(rec[2]), 32'h4);
    chk("rr_g3", 32'(rec[3]), 32'h1);
    chk("rr_g4", 32'(rec[4]), 32'h2);
    chk("rr_g5", 32'(rec[5]), 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
